// File: rtl/uart_fifo_core.sv
// UART core: TX word FIFO feeding a frame shifter, plus an independent oversampling-free
// mid-bit RX deserialiser. Frame = start, DATA_WIDTH bits LSB first, optional parity, stop.
module uart_fifo_core #(
  parameter int unsigned CLOCKS_PER_PULSE = 5208,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter bit          PARITY_EN        = 1'b0,
  parameter bit          PARITY_ODD       = 1'b0,
  parameter int unsigned TX_FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic                  data_en,
  output logic                  tx_full,
  output logic                  tx_busy,
  output logic                  tx,
  input  logic                  rx,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int unsigned CW = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned IW = $clog2(DATA_WIDTH);
  localparam int unsigned AW = $clog2(TX_FIFO_DEPTH);

  localparam logic [CW-1:0] BitLast  = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] HalfLast = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   FifoFull = (AW + 1)'(TX_FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_WIDTH-1:0] fifo_mem [TX_FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q;
  logic                  fifo_empty, push, pop;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign fifo_empty = (count_q == '0);
  assign tx_full    = (count_q == FifoFull);
  assign push       = data_en && !tx_full;
  assign fifo_head  = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= data_input;
  end

  // ---------------------------------------------------------------- TX shifter
  state_e                tx_state_q;
  logic [CW-1:0]         tx_cyc_q;
  logic [IW-1:0]         tx_idx_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic                  tx_par_q, tx_q, tx_line_busy_q, tx_bit_end;

  assign tx_bit_end = (tx_cyc_q == BitLast);
  // Pop either from idle or on the last cycle of a stop bit, so frames run back to back.
  assign pop     = !fifo_empty && ((tx_state_q == StIdle) || (tx_state_q == StStop && tx_bit_end));
  assign tx      = tx_q;
  // tx is registered one cycle behind the state, so the stop bit outlives StStop by a cycle.
  assign tx_busy = !fifo_empty || (tx_state_q != StIdle) || tx_line_busy_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q     <= StIdle;
      tx_cyc_q       <= '0;
      tx_idx_q       <= '0;
      tx_shift_q     <= '0;
      tx_par_q       <= 1'b0;
      tx_q           <= 1'b1;
      tx_line_busy_q <= 1'b0;
    end else begin
      tx_line_busy_q <= (tx_state_q != StIdle);
      unique case (tx_state_q)
        StStart:  tx_q <= 1'b0;
        StData:   tx_q <= tx_shift_q[0];
        StParity: tx_q <= tx_par_q;
        default:  tx_q <= 1'b1;
      endcase

      if (tx_state_q == StIdle) begin
        if (pop) begin
          tx_shift_q <= fifo_head;
          tx_par_q   <= ^fifo_head ^ PARITY_ODD;
          tx_cyc_q   <= '0;
          tx_state_q <= StStart;
        end
      end else if (!tx_bit_end) begin
        tx_cyc_q <= tx_cyc_q + CW'(1);
      end else begin
        tx_cyc_q <= '0;
        unique case (tx_state_q)
          StStart: begin
            tx_idx_q   <= '0;
            tx_state_q <= StData;
          end
          StData: begin
            tx_shift_q <= tx_shift_q >> 1;
            if (tx_idx_q == IdxLast) tx_state_q <= PARITY_EN ? StParity : StStop;
            else                     tx_idx_q   <= tx_idx_q + IW'(1);
          end
          StParity: tx_state_q <= StStop;
          StStop: begin
            if (pop) begin
              tx_shift_q <= fifo_head;
              tx_par_q   <= ^fifo_head ^ PARITY_ODD;
              tx_state_q <= StStart;
            end else begin
              tx_state_q <= StIdle;
            end
          end
          default: tx_state_q <= StIdle;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- RX
  logic [1:0]            rx_sync_q;
  logic                  rx_s, rx_prev_q, rx_par_q, rx_bit_end;
  state_e                rx_state_q;
  logic [CW-1:0]         rx_cyc_q;
  logic [IW-1:0]         rx_idx_q;
  logic [DATA_WIDTH-1:0] rx_shift_q;

  assign rx_s       = rx_sync_q[1];
  assign rx_bit_end = (rx_cyc_q == BitLast);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_sync_q   <= 2'b11;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= StIdle;
      rx_cyc_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      rx_par_q    <= 1'b0;
      data_output <= '0;
      ready       <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rx};
      rx_prev_q  <= rx_s;
      ready      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      unique case (rx_state_q)
        StIdle: begin
          if (rx_prev_q && !rx_s) begin
            rx_cyc_q   <= '0;
            rx_state_q <= StStart;
          end
        end
        StStart: begin
          if (rx_cyc_q == HalfLast) begin
            // A line already back high at mid-start is a glitch, not a frame.
            rx_cyc_q   <= '0;
            rx_idx_q   <= '0;
            rx_state_q <= rx_s ? StIdle : StData;
          end else begin
            rx_cyc_q <= rx_cyc_q + CW'(1);
          end
        end
        StData: begin
          if (rx_bit_end) begin
            rx_cyc_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[DATA_WIDTH-1:1]};
            if (rx_idx_q == IdxLast) rx_state_q <= PARITY_EN ? StParity : StStop;
            else                     rx_idx_q   <= rx_idx_q + IW'(1);
          end else begin
            rx_cyc_q <= rx_cyc_q + CW'(1);
          end
        end
        StParity: begin
          if (rx_bit_end) begin
            rx_cyc_q   <= '0;
            rx_par_q   <= rx_s;
            rx_state_q <= StStop;
          end else begin
            rx_cyc_q <= rx_cyc_q + CW'(1);
          end
        end
        StStop: begin
          if (rx_bit_end) begin
            rx_cyc_q   <= '0;
            rx_state_q <= StIdle;
            if (rx_s) begin
              data_output <= rx_shift_q;
              ready       <= 1'b1;
              parity_err  <= PARITY_EN && ((^rx_shift_q ^ PARITY_ODD) != rx_par_q);
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            rx_cyc_q <= rx_cyc_q + CW'(1);
          end
        end
        default: rx_state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Randomised bench for uart_fifo_core: a transaction-level TX model (queue occupancy and
// frame timing) checked every cycle, plus RX frames driven bit by bit from the frame rules.
module tb_uart_fifo_core;

  localparam int unsigned CPP   = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = (DW + 2) * CPP;

  logic          clk, rstn;
  logic [DW-1:0] data_input, data_output;
  logic          data_en, tx_full, tx_busy, tx, rx_line, ready, parity_err, frame_err;
  logic          loop, rx_drv;

  logic [DW-1:0] data_in_p, data_output_p;
  logic          data_en_p, tx_full_p, tx_busy_p, tx_p, rx_p, ready_p, parity_err_p, frame_err_p;

  assign rx_line = loop ? tx : rx_drv;

  uart_fifo_core #(
    .CLOCKS_PER_PULSE(CPP), .DATA_WIDTH(DW), .PARITY_EN(1'b0), .PARITY_ODD(1'b0),
    .TX_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .data_input(data_input), .data_en(data_en), .tx_full(tx_full),
    .tx_busy(tx_busy), .tx(tx), .rx(rx_line), .ready(ready), .data_output(data_output),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  uart_fifo_core #(
    .CLOCKS_PER_PULSE(CPP), .DATA_WIDTH(DW), .PARITY_EN(1'b1), .PARITY_ODD(1'b0),
    .TX_FIFO_DEPTH(DEPTH)
  ) dut_p (
    .clk(clk), .rstn(rstn), .data_input(data_in_p), .data_en(data_en_p), .tx_full(tx_full_p),
    .tx_busy(tx_busy_p), .tx(tx_p), .rx(rx_p), .ready(ready_p), .data_output(data_output_p),
    .parity_err(parity_err_p), .frame_err(frame_err_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------------------------------------------------------- reference model
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_sent[$];
  logic [DW-1:0] m_word;
  int            m_left;
  logic          m_exp_tx, m_exp_busy, m_exp_full;

  // Bit idx of a frame: 0 start, 1..DW data LSB first, then optional parity, then stop.
  function automatic logic frame_bit(input logic [DW-1:0] w, input int idx, input bit pe,
                                     input logic par, input logic stop);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return w[idx-1];
    if (pe && idx == DW + 1) return par;
    return stop;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_sent.delete();
    m_left     = 0;
    m_word     = '0;
    m_exp_tx   = 1'b1;
    m_exp_busy = 1'b0;
    m_exp_full = 1'b0;
  endtask

  // One clock edge: the line shows the frame in flight before the edge; a new word is
  // taken as soon as the previous frame's last cycle is reached; writes to a full queue vanish.
  task automatic model_edge(input logic en, input logic [DW-1:0] d);
    int            left_b = m_left;
    logic [DW-1:0] word_b = m_word;
    bit            can_push = (m_q.size() < DEPTH);
    m_exp_tx = (left_b > 0) ? frame_bit(word_b, (FRAME - left_b) / CPP, 1'b0, 1'b0, 1'b1) : 1'b1;
    if (m_left > 0) m_left--;
    if (m_left == 0 && m_q.size() > 0) begin
      m_word = m_q.pop_front();
      m_sent.push_back(m_word);
      m_left = FRAME;
    end
    if (en && can_push) m_q.push_back(d);
    m_exp_busy = (m_q.size() > 0) || (m_left > 0) || (left_b > 0);
    m_exp_full = (m_q.size() == DEPTH);
  endtask

  task automatic cycle(input logic en, input logic [DW-1:0] d, input logic rb, input logic rpb);
    @(negedge clk);
    data_en    = en;
    data_input = d;
    rx_drv     = rb;
    rx_p       = rpb;
    @(posedge clk);
    model_edge(en, d);
  endtask

  // ---------------------------------------------------------------- RX monitors
  logic [DW-1:0] got[$];
  logic [DW-1:0] gotp[$];
  bit            gotp_pe[$];
  int            perr_cnt = 0, ferr_cnt = 0, strayp = 0;

  always @(posedge clk) begin
    #1;
    if (ready) got.push_back(data_output);
    if (parity_err) perr_cnt++;
    if (frame_err) ferr_cnt++;
    if (ready_p) begin
      gotp.push_back(data_output_p);
      gotp_pe.push_back(parity_err_p);
    end
    if (parity_err_p && !ready_p) strayp++;
  end

  // Drive one frame onto the plain (to_p=0) or parity (to_p=1) RX input, then idle high.
  task automatic send_rx(input bit to_p, input logic [DW-1:0] w, input logic par,
                         input logic stop);
    int nb = to_p ? DW + 3 : DW + 2;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < CPP; k++) begin
        if (to_p) cycle(1'b0, '0, 1'b1, frame_bit(w, b, 1'b1, par, stop));
        else      cycle(1'b0, '0, frame_bit(w, b, 1'b0, 1'b0, stop), 1'b1);
      end
    end
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b1);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rstn = 1'b0; loop = 1'b0; rx_drv = 1'b1; rx_p = 1'b1;
    data_en = 1'b0; data_input = '0; data_en_p = 1'b0; data_in_p = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    if ({tx, tx_busy, tx_full, ready, parity_err, frame_err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 100000",
               {tx, tx_busy, tx_full, ready, parity_err, frame_err});
    end
    checks++;
    if (data_output !== '0 || tx_p !== 1'b1) begin
      errors++;
      $display("FAIL reset_data: data_output %h tx_p %b, want 00 1", data_output, tx_p);
    end
    checks++;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_tx_word(input logic [DW-1:0] w);
    cycle(1'b1, w, 1'b1, 1'b1);
    #1;
    for (int c = 0; c < FRAME + 6; c++) begin
      cycle(1'b0, '0, 1'b1, 1'b1);
      #1;
      if ({tx, tx_busy, tx_full} !== {m_exp_tx, m_exp_busy, m_exp_full}) begin
        errors++;
        $display("FAIL tx_word %h cyc %0d: tx/busy/full got %b%b%b want %b%b%b", w, c,
                 tx, tx_busy, tx_full, m_exp_tx, m_exp_busy, m_exp_full);
      end
      checks++;
      // Start bit appears two edges after the write edge, not one.
      if ((c == 0 && tx !== 1'b1) || (c == 1 && tx !== 1'b0)) begin
        errors++;
        $display("FAIL tx_latency %h cyc %0d: tx got %b", w, c, tx);
      end
      if (c < 2) checks++;
    end
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL tx_idle %h: tx_busy got %b want 0", w, tx_busy);
    end
    checks++;
  endtask

  task automatic test_tx_frames();
    test_tx_word(8'hA5);
    for (int i = 0; i < 3; i++) test_tx_word(DW'($urandom));
  endtask

  task automatic drain_and_compare(input string tag);
    int idle = 0;
    for (int c = 0; c < 4000 && idle < 30; c++) begin
      cycle(1'b0, '0, 1'b1, 1'b1);
      #1;
      if ({tx, tx_busy, tx_full} !== {m_exp_tx, m_exp_busy, m_exp_full}) begin
        errors++;
        $display("FAIL %s drain cyc %0d: tx/busy/full got %b%b%b want %b%b%b", tag, c,
                 tx, tx_busy, tx_full, m_exp_tx, m_exp_busy, m_exp_full);
      end
      checks++;
      if (!m_exp_busy) idle++;
    end
    if (idle < 30) begin
      errors++;
      $display("FAIL %s drain_timeout: model still busy", tag);
    end
    checks++;
    if (got.size() != m_sent.size()) begin
      errors++;
      $display("FAIL %s rx_count: got %0d want %0d", tag, got.size(), m_sent.size());
    end
    checks++;
    for (int i = 0; i < m_sent.size() && i < got.size(); i++) begin
      if (got[i] !== m_sent[i]) begin
        errors++;
        $display("FAIL %s rx_word %0d: got %h want %h", tag, i, got[i], m_sent[i]);
      end
      checks++;
    end
    if (perr_cnt != 0 || ferr_cnt != 0) begin
      errors++;
      $display("FAIL %s rx_errs: parity %0d frame %0d want 0 0", tag, perr_cnt, ferr_cnt);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words[4] = '{8'h00, 8'hFF, 8'h3C, 8'h81};
    loop = 1'b1;
    got.delete(); m_sent.delete(); perr_cnt = 0; ferr_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, words[i], 1'b1, 1'b1);
      #1;
      if ({tx, tx_busy, tx_full} !== {m_exp_tx, m_exp_busy, m_exp_full}) begin
        errors++;
        $display("FAIL b2b write %0d: tx/busy/full got %b%b%b want %b%b%b", i,
                 tx, tx_busy, tx_full, m_exp_tx, m_exp_busy, m_exp_full);
      end
      checks++;
    end
    drain_and_compare("b2b");
    loop = 1'b0;
  endtask

  task automatic test_overflow();
    loop = 1'b1;
    got.delete(); m_sent.delete(); perr_cnt = 0; ferr_cnt = 0;
    // Keep writing through full periods, including the pop cycles themselves.
    for (int c = 0; c < 200; c++) begin
      cycle(1'b1, DW'($urandom), 1'b1, 1'b1);
      #1;
      if ({tx, tx_busy, tx_full} !== {m_exp_tx, m_exp_busy, m_exp_full}) begin
        errors++;
        $display("FAIL ovf cyc %0d: tx/busy/full got %b%b%b want %b%b%b", c,
                 tx, tx_busy, tx_full, m_exp_tx, m_exp_busy, m_exp_full);
      end
      checks++;
    end
    drain_and_compare("ovf");
    loop = 1'b0;
  endtask

  task automatic test_frame_err();
    logic [DW-1:0] w0 = DW'($urandom) | 8'h01;
    int            f0;
    got.delete(); ferr_cnt = 0;
    send_rx(1'b0, w0, 1'b0, 1'b1);
    if (got.size() != 1 || got[0] !== w0) begin
      errors++;
      $display("FAIL ferr_good: got %0d words first %h want 1 word %h", got.size(),
               (got.size() > 0) ? got[0] : 8'h00, w0);
    end
    checks++;
    f0 = ferr_cnt;
    send_rx(1'b0, 8'h55, 1'b0, 1'b0);
    if (got.size() != 1 || ferr_cnt != f0 + 1 || data_output !== w0) begin
      errors++;
      $display("FAIL ferr_stop0: words %0d ferr %0d data %h want 1 %0d %h", got.size(),
               ferr_cnt, data_output, f0 + 1, w0);
    end
    checks++;
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    repeat (30) cycle(1'b0, '0, 1'b1, 1'b1);
    if (got.size() != 1 || ferr_cnt != f0 + 1 || perr_cnt != 0) begin
      errors++;
      $display("FAIL glitch: words %0d ferr %0d perr %0d want 1 %0d 0", got.size(), ferr_cnt,
               perr_cnt, f0 + 1);
    end
    checks++;
  endtask

  task automatic test_parity();
    gotp.delete(); gotp_pe.delete(); strayp = 0;
    send_rx(1'b1, 8'h07, 1'b0, 1'b1);
    if (gotp.size() != 1 || gotp[0] !== 8'h07 || gotp_pe[0] !== 1'b1) begin
      errors++;
      $display("FAIL parity_07: words %0d data %h pe %b want 1 07 1", gotp.size(),
               (gotp.size() > 0) ? gotp[0] : 8'h00, (gotp_pe.size() > 0) ? gotp_pe[0] : 1'b0);
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] w = DW'($urandom);
      logic          good = ^w;
      logic          par = (i % 2 == 0) ? good : ~good;
      gotp.delete(); gotp_pe.delete();
      send_rx(1'b1, w, par, 1'b1);
      if (gotp.size() != 1 || gotp[0] !== w || gotp_pe[0] !== (par != good)) begin
        errors++;
        $display("FAIL parity_rand %0d: words %0d data %h pe %b want 1 %h %b", i, gotp.size(),
                 (gotp.size() > 0) ? gotp[0] : 8'h00,
                 (gotp_pe.size() > 0) ? gotp_pe[0] : 1'b0, w, par != good);
      end
      checks++;
    end
    if (strayp != 0) begin
      errors++;
      $display("FAIL parity_stray: got %0d lone parity_err pulses want 0", strayp);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w_t = DW'($urandom);
    logic [DW-1:0] w_r = DW'($urandom);
    logic [DW-1:0] w_2 = DW'($urandom);
    loop = 1'b0;
    for (int c = 0; c < 44; c++) begin
      cycle(c == 0, w_t, frame_bit(w_r, c / CPP, 1'b0, 1'b0, 1'b1), 1'b1);
    end
    #3;
    rstn = 1'b0;
    #1;
    if ({tx, tx_busy, tx_full, ready, parity_err, frame_err} !== 6'b100000 ||
        data_output !== '0) begin
      errors++;
      $display("FAIL reset_mid: flags %b data %h want 100000 00",
               {tx, tx_busy, tx_full, ready, parity_err, frame_err}, data_output);
    end
    checks++;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rx_drv = 1'b1;
    data_en = 1'b0;
    rstn = 1'b1;
    got.delete(); ferr_cnt = 0; perr_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      cycle(1'b0, '0, 1'b1, 1'b1);
      #1;
      if ({tx, tx_busy, tx_full} !== {m_exp_tx, m_exp_busy, m_exp_full}) begin
        errors++;
        $display("FAIL post_reset cyc %0d: tx/busy/full got %b%b%b want %b%b%b", c,
                 tx, tx_busy, tx_full, m_exp_tx, m_exp_busy, m_exp_full);
      end
      checks++;
    end
    if (got.size() != 0 || ferr_cnt != 0) begin
      errors++;
      $display("FAIL post_reset_rx: words %0d ferr %0d want 0 0", got.size(), ferr_cnt);
    end
    checks++;
    send_rx(1'b0, w_2, 1'b0, 1'b1);
    if (got.size() != 1 || got[0] !== w_2) begin
      errors++;
      $display("FAIL post_reset_frame: words %0d data %h want 1 %h", got.size(),
               (got.size() > 0) ? got[0] : 8'h00, w_2);
    end
    checks++;
    test_tx_word(DW'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tx_frames();
    test_back_to_back();
    test_overflow();
    test_frame_err();
    test_parity();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
